// File: rtl/shift_sequencer.sv
// Multi-cycle shift/rotate sequencer: one single-bit step through carry per clock,
// with a start/busy/done handshake and registered result, carry and zero flags.
//
// state   | meaning
// S_IDLE  | waiting for start; result/carry_out/zero hold the last completion
// S_SHIFT | applying one step per edge; start ignored
// S_DONE  | one-cycle done pulse; a new start is accepted here as in S_IDLE
module shift_sequencer #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [CNT_W-1:0] count,
  input  logic [WIDTH-1:0] operand,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             zero
);

  localparam logic [1:0] OP_RRC = 2'b00;
  localparam logic [1:0] OP_ASR = 2'b01;
  localparam logic [1:0] OP_LSR = 2'b10;
  localparam logic [1:0] OP_RLC = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, step_a;
  logic             c_q, step_c;
  logic [1:0]       op_q;
  logic [CNT_W-1:0] cnt_q;
  logic             accept;
  logic             last_step;

  assign accept    = start && (state_q != S_SHIFT);
  assign last_step = (state_q == S_SHIFT) && (cnt_q == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start)                state_d = (count == '0) ? S_DONE : S_SHIFT;
        else if (state_q == S_DONE) state_d = S_IDLE;
      end
      S_SHIFT: if (cnt_q == CNT_W'(1)) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == S_SHIFT);
    done = (state_q == S_DONE);
  end

  // One step of the 17-bit {C,A} datapath for the latched operation.
  always_comb begin
    step_a = a_q;
    step_c = c_q;
    case (op_q)
      OP_RRC: begin step_c = a_q[0];       step_a = {c_q, a_q[WIDTH-1:1]};        end
      OP_ASR: begin step_c = a_q[0];       step_a = {a_q[WIDTH-1], a_q[WIDTH-1:1]}; end
      OP_LSR: begin step_c = a_q[0];       step_a = {1'b0, a_q[WIDTH-1:1]};       end
      OP_RLC: begin step_c = a_q[WIDTH-1]; step_a = {a_q[WIDTH-2:0], c_q};        end
      default: begin step_a = a_q; step_c = c_q; end
    endcase
  end

  // Visible flags only move on completion, so the status register never sees partial shifts.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q       <= '0;
      c_q       <= 1'b0;
      op_q      <= OP_RRC;
      cnt_q     <= '0;
      result    <= '0;
      carry_out <= 1'b0;
      zero      <= 1'b1;
    end else if (accept) begin
      a_q   <= operand;
      c_q   <= carry_in;
      op_q  <= op;
      cnt_q <= count;
      if (count == '0) begin
        result    <= operand;
        carry_out <= carry_in;
        zero      <= (operand == '0);
      end
    end else if (state_q == S_SHIFT) begin
      a_q   <= step_a;
      c_q   <= step_c;
      cnt_q <= cnt_q - CNT_W'(1);
      if (last_step) begin
        result    <= step_a;
        carry_out <= step_c;
        zero      <= (step_a == '0);
      end
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: directed cases plus randomized operations checked
// against an arithmetic rotate/shift reference model.
module tb_shift_sequencer;
  localparam int WIDTH = 16;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [1:0]       op;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] operand;
  logic             carry_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             zero;

  int vectors = 0;
  int miscompares = 0;

  logic [WIDTH-1:0] exp_res;
  logic             exp_c;
  logic             exp_z;

  shift_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .count(count),
    .operand(operand), .carry_in(carry_in), .busy(busy), .done(done),
    .result(result), .carry_out(carry_out), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // RRC/RLC are rotates of the 17-bit value {C,A}; ASR/LSR are plain n-bit shifts
  // whose carry is the last bit shifted out (or carry_in when n=0).
  function automatic void model(input logic [1:0] f_op, input int n, input logic [WIDTH-1:0] a,
                                input logic c, output logic [WIDTH-1:0] r, output logic co);
    logic [WIDTH:0]        x;
    logic signed [WIDTH-1:0] sa;
    x  = {c, a};
    sa = a;
    r  = a;
    co = c;
    case (f_op)
      2'b00: begin x = (x >> n) | (x << (WIDTH + 1 - n)); {co, r} = x; end
      2'b11: begin x = (x << n) | (x >> (WIDTH + 1 - n)); {co, r} = x; end
      2'b01: begin r = sa >>> n; co = (n == 0) ? c : a[n-1]; end
      default: begin r = a >> n; co = (n == 0) ? c : a[n-1]; end
    endcase
  endfunction

  // Called at a negedge; launches the op there and returns at the negedge where done is seen.
  task automatic run_op(input logic [1:0] t_op, input int n, input logic [WIDTH-1:0] a,
                        input logic c, input bit poke, input string tag);
    logic [WIDTH-1:0] mr;
    logic             mc;
    int cyc, busy_cyc, held_err;
    model(t_op, n, a, c, mr, mc);
    start = 1'b1; op = t_op; count = CNT_W'(n); operand = a; carry_in = c;
    @(negedge clk);
    start = 1'b0; op = 2'($urandom); count = CNT_W'($urandom);
    operand = WIDTH'($urandom); carry_in = 1'($urandom);
    cyc = 0; busy_cyc = 0; held_err = 0;
    while (!done && cyc < 64) begin
      if (busy) busy_cyc++;
      if (result !== exp_res || carry_out !== exp_c || zero !== exp_z) held_err++;
      start   = poke ? 1'($urandom) : 1'b0;
      operand = WIDTH'($urandom);
      count   = CNT_W'($urandom);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    exp_res = mr; exp_c = mc; exp_z = (mr == '0);
    check({tag, "_latency"}, cyc, n);
    check({tag, "_busy_cycles"}, busy_cyc, n);
    check({tag, "_held"}, held_err, 0);
    check({tag, "_result"}, result, mr);
    check({tag, "_carry"}, carry_out, mc);
    check({tag, "_zero"}, zero, (mr == '0));
    check({tag, "_busy_at_done"}, busy, 1'b0);
  endtask

  task automatic idle_check(input string tag);
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 1'b0);
    check({tag, "_idle_busy"}, busy, 1'b0);
    check({tag, "_idle_result"}, {carry_out, zero, result}, {exp_c, exp_z, exp_res});
  endtask

  initial begin
    int dones;
    reset = 1'b1; start = 1'b1; op = 2'b00; count = 4'd5; operand = 16'h1111; carry_in = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_result", result, 16'h0000);
    check("rst_carry", carry_out, 1'b0);
    check("rst_zero", zero, 1'b1);
    exp_res = '0; exp_c = 1'b0; exp_z = 1'b1;
    reset = 1'b0; start = 1'b0;
    idle_check("post_rst");

    run_op(2'b00, 4, 16'h1234, 1'b1, 1'b0, "t1_rrc");
    check("t1_const", {carry_out, zero, result}, {1'b0, 1'b0, 16'h9123});
    idle_check("t1");
    run_op(2'b01, 3, 16'h8010, 1'b0, 1'b0, "t2_asr");
    check("t2_const", {carry_out, result}, {1'b0, 16'hF002});
    idle_check("t2");
    run_op(2'b10, 15, 16'hFFFF, 1'b0, 1'b0, "t3_lsr");
    check("t3_const", {carry_out, result}, {1'b1, 16'h0001});
    idle_check("t3");
    run_op(2'b11, 1, 16'h8000, 1'b0, 1'b0, "t4_rlc");
    check("t4_const", {carry_out, zero, result}, {1'b1, 1'b1, 16'h0000});
    idle_check("t4");
    run_op(2'b10, 0, 16'hABCD, 1'b1, 1'b0, "t5_cnt0");
    check("t5_const", {carry_out, result}, {1'b1, 16'hABCD});
    idle_check("t5");

    run_op(2'b11, 10, 16'h5A5A, 1'b1, 1'b1, "t6_poke");
    idle_check("t6");

    run_op(2'b00, 3, 16'hC3A5, 1'b0, 1'b0, "b2b_first");
    run_op(2'b01, 2, 16'h9001, 1'b1, 1'b0, "b2b_second");
    run_op(2'b10, 0, 16'h0000, 1'b0, 1'b0, "b2b_third");
    idle_check("b2b");

    // reset sampled on edge 2 of a count=8 rotate
    start = 1'b1; op = 2'b00; count = 4'd8; operand = 16'h7E81; carry_in = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("midrst_busy_before", busy, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_outputs", {carry_out, zero, result}, {1'b0, 1'b1, 16'h0000});
    exp_res = '0; exp_c = 1'b0; exp_z = 1'b1;
    dones = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("midrst_no_done", dones, 0);
    check("midrst_held", {carry_out, zero, result}, {exp_c, exp_z, exp_res});

    for (int i = 0; i < 40; i++) begin
      run_op(2'($urandom), $urandom_range(0, 15), WIDTH'($urandom), 1'($urandom),
             1'($urandom), "rnd");
      if ($urandom_range(0, 1) == 1 || i == 39) idle_check("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
